// File: rtl/uart_tx_arb.sv
// Two-source UART transmitter: arbitrates debug-bridge and SoC UART bytes onto one
// 8N1 serial line, limiting debug bursts while the SoC UART is waiting.
module uart_tx_arb #(
  parameter int unsigned CLK_FREQ      = 32000000,
  parameter int unsigned BAUDRATE      = 1000000,
  parameter int unsigned MAX_DBG_BURST = 4
) (
  input  logic       clk32_i,
  input  logic       rst,
  input  logic       dbg_valid_i,
  input  logic [7:0] dbg_data_i,
  output logic       dbg_accept_o,
  input  logic       uart_valid_i,
  input  logic [7:0] uart_data_i,
  output logic       uart_accept_o,
  output logic       txd_o,
  output logic       busy_o,
  output logic       owner_o
);

  localparam int unsigned DIV       = CLK_FREQ / BAUDRATE;
  localparam logic [15:0] BIT_LAST  = 16'(DIV - 1);
  localparam logic [7:0]  BURST_MAX = 8'(MAX_DBG_BURST);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic [7:0]  burst_cnt;
  logic        dbg_sel;
  logic        uart_sel;
  logic        bit_end;

  // Debug has priority unless it has used up its burst allowance while the SoC UART waits
  assign dbg_sel  = (state == IDLE) && !rst && dbg_valid_i &&
                    (!uart_valid_i || (burst_cnt != BURST_MAX));
  assign uart_sel = (state == IDLE) && !rst && uart_valid_i && !dbg_sel;

  assign dbg_accept_o  = dbg_sel;
  assign uart_accept_o = uart_sel;
  assign bit_end       = (bit_cnt == 16'd0);

  always_ff @(posedge clk32_i or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= 16'd0;
      bit_idx   <= 3'd0;
      shreg     <= 8'd0;
      burst_cnt <= 8'd0;
      txd_o     <= 1'b1;
      busy_o    <= 1'b0;
      owner_o   <= 1'b0;
    end else begin
      if (uart_sel)
        burst_cnt <= 8'd0;
      else if (dbg_sel && uart_valid_i)
        burst_cnt <= burst_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (dbg_sel || uart_sel) begin
            state   <= START;
            shreg   <= uart_sel ? uart_data_i : dbg_data_i;
            owner_o <= uart_sel;
            busy_o  <= 1'b1;
            txd_o   <= 1'b0;
            bit_cnt <= BIT_LAST;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= 3'd0;
            txd_o   <= shreg[0];
            bit_cnt <= BIT_LAST;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= BIT_LAST;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd_o <= 1'b1;
            end else begin
              // LSB-first: shift the next bit into position 0
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              txd_o   <= shreg[1];
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb at DIV = 32, MAX_DBG_BURST = 4.
module tb_uart_tx_arb;

  logic       clk32_i = 1'b0;
  logic       rst = 1'b0;
  logic       dbg_valid_i = 1'b0;
  logic [7:0] dbg_data_i = 8'h00;
  logic       dbg_accept_o;
  logic       uart_valid_i = 1'b0;
  logic [7:0] uart_data_i = 8'h00;
  logic       uart_accept_o;
  logic       txd_o;
  logic       busy_o;
  logic       owner_o;

  int n_checks = 0;
  int n_fails  = 0;

  uart_tx_arb dut (
    .clk32_i      (clk32_i),
    .rst          (rst),
    .dbg_valid_i  (dbg_valid_i),
    .dbg_data_i   (dbg_data_i),
    .dbg_accept_o (dbg_accept_o),
    .uart_valid_i (uart_valid_i),
    .uart_data_i  (uart_data_i),
    .uart_accept_o(uart_accept_o),
    .txd_o        (txd_o),
    .busy_o       (busy_o),
    .owner_o      (owner_o)
  );

  always #5 clk32_i = ~clk32_i;

  // Called at the negedge where the accept was seen; walks the 320-cycle frame and the idle cycle after.
  task automatic check_frame(input logic [7:0] b, input logic own, input string name);
    logic [9:0] seq;
    seq = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 32; j++) begin
        @(negedge clk32_i);
        dbg_valid_i  = 1'b0;
        uart_valid_i = 1'b0;
        dbg_data_i   = 8'hFF;
        uart_data_i  = 8'hFF;
        #1;
        n_checks++;
        if (txd_o !== seq[i] || busy_o !== 1'b1 || owner_o !== own ||
            dbg_accept_o !== 1'b0 || uart_accept_o !== 1'b0) begin
          n_fails++;
          $display("FAIL %s bit%0d cyc%0d: txd=%b busy=%b owner=%b acc=%b%b, want txd=%b busy=1 owner=%b acc=00",
                   name, i, j, txd_o, busy_o, owner_o, dbg_accept_o, uart_accept_o, seq[i], own);
        end
      end
    end
    @(negedge clk32_i);
    #1;
    n_checks++;
    if (busy_o !== 1'b0 || txd_o !== 1'b1 || owner_o !== own) begin
      n_fails++;
      $display("FAIL %s end: busy=%b txd=%b owner=%b, want busy=0 txd=1 owner=%b",
               name, busy_o, txd_o, owner_o, own);
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy_o !== 1'b0 && k < 1000) begin
      @(negedge clk32_i);
      #1;
      k++;
    end
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fails++;
      $display("FAIL %s idle timeout: busy=%b, want 0", name, busy_o);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    dbg_valid_i  = 1'b1;
    uart_valid_i = 1'b1;
    #1;
    n_checks++;
    if (txd_o !== 1'b1 || busy_o !== 1'b0 || owner_o !== 1'b0 ||
        dbg_accept_o !== 1'b0 || uart_accept_o !== 1'b0 || dut.burst_cnt !== 8'd0) begin
      n_fails++;
      $display("FAIL reset: txd=%b busy=%b owner=%b acc=%b%b burst=%0d, want 1 0 0 00 0",
               txd_o, busy_o, owner_o, dbg_accept_o, uart_accept_o, dut.burst_cnt);
    end
    dbg_valid_i  = 1'b0;
    uart_valid_i = 1'b0;
    repeat (3) @(negedge clk32_i);
    rst = 1'b0;
  endtask

  task automatic test_dbg_byte();
    @(negedge clk32_i);
    dbg_valid_i = 1'b1;
    dbg_data_i  = 8'hA5;
    #1;
    n_checks++;
    if (dbg_accept_o !== 1'b1 || uart_accept_o !== 1'b0) begin
      n_fails++;
      $display("FAIL dbg_accept: acc=%b%b, want 10", dbg_accept_o, uart_accept_o);
    end
    check_frame(8'hA5, 1'b0, "dbg_a5");
  endtask

  task automatic test_uart_byte();
    @(negedge clk32_i);
    uart_valid_i = 1'b1;
    uart_data_i  = 8'h00;
    #1;
    n_checks++;
    if (uart_accept_o !== 1'b1 || dbg_accept_o !== 1'b0) begin
      n_fails++;
      $display("FAIL uart_accept: acc=%b%b, want 01", dbg_accept_o, uart_accept_o);
    end
    check_frame(8'h00, 1'b1, "uart_00");
  endtask

  task automatic test_back_to_back();
    string exp_order, got;
    int cyc, last, grants;
    exp_order = "DDDDUDDDDU";
    got = "";
    cyc = 0;
    last = 0;
    grants = 0;
    @(negedge clk32_i);
    dbg_valid_i  = 1'b1;
    uart_valid_i = 1'b1;
    dbg_data_i   = 8'h11;
    uart_data_i  = 8'h22;
    while (grants < 10 && cyc < 4000) begin
      #1;
      if (dbg_accept_o === 1'b1 && uart_accept_o === 1'b1) begin
        n_checks++;
        n_fails++;
        $display("FAIL b2b both accepts at cycle %0d", cyc);
      end
      if (dbg_accept_o === 1'b1 || uart_accept_o === 1'b1) begin
        got = {got, (dbg_accept_o === 1'b1) ? "D" : "U"};
        if (grants > 0) begin
          n_checks++;
          if (cyc - last != 321) begin
            n_fails++;
            $display("FAIL b2b spacing grant%0d: got %0d cycles, want 321", grants, cyc - last);
          end
        end
        last = cyc;
        grants++;
      end
      @(negedge clk32_i);
      cyc++;
    end
    dbg_valid_i  = 1'b0;
    uart_valid_i = 1'b0;
    n_checks++;
    if (got != exp_order) begin
      n_fails++;
      $display("FAIL b2b order: got %s, want %s", got, exp_order);
    end
    wait_idle("b2b");
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk32_i);
    dbg_valid_i = 1'b1;
    dbg_data_i  = 8'hFF;
    // Data bit 3 spans negedges 129..160 after the accept
    repeat (140) @(negedge clk32_i);
    dbg_valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (txd_o !== 1'b1 || busy_o !== 1'b0 || dbg_accept_o !== 1'b0) begin
      n_fails++;
      $display("FAIL mid_reset: txd=%b busy=%b acc=%b, want 1 0 0", txd_o, busy_o, dbg_accept_o);
    end
    repeat (2) @(negedge clk32_i);
    rst = 1'b0;
    uart_valid_i = 1'b1;
    uart_data_i  = 8'h3C;
    #1;
    n_checks++;
    if (uart_accept_o !== 1'b1) begin
      n_fails++;
      $display("FAIL first_accept_after_reset: uart_accept=%b, want 1", uart_accept_o);
    end
    check_frame(8'h3C, 1'b1, "after_reset_3c");
  endtask

  task automatic test_busy_pulse();
    int extra;
    extra = 0;
    @(negedge clk32_i);
    uart_valid_i = 1'b1;
    uart_data_i  = 8'h55;
    @(negedge clk32_i);
    uart_valid_i = 1'b0;
    repeat (50) @(negedge clk32_i);
    dbg_valid_i = 1'b1;
    dbg_data_i  = 8'h77;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (dbg_accept_o !== 1'b0) extra++;
      @(negedge clk32_i);
    end
    dbg_valid_i = 1'b0;
    wait_idle("busy_pulse");
    for (int i = 0; i < 400; i++) begin
      @(negedge clk32_i);
      #1;
      if (dbg_accept_o !== 1'b0 || busy_o !== 1'b0) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fails++;
      $display("FAIL busy_pulse: %0d cycles with accept or busy, want 0", extra);
    end
  endtask

  task automatic test_burst_limit();
    int grants, cyc;
    grants = 0;
    cyc = 0;
    @(negedge clk32_i);
    dbg_valid_i  = 1'b1;
    uart_valid_i = 1'b1;
    while (grants < 4 && cyc < 2000) begin
      #1;
      if (dbg_accept_o === 1'b1) grants++;
      @(negedge clk32_i);
      cyc++;
    end
    dbg_valid_i  = 1'b0;
    uart_valid_i = 1'b0;
    wait_idle("burst_fill");
    repeat (3) @(negedge clk32_i);
    #1;
    n_checks++;
    if (dut.burst_cnt !== 8'd4) begin
      n_fails++;
      $display("FAIL burst_fill: burst_cnt=%0d, want 4", dut.burst_cnt);
    end
    @(negedge clk32_i);
    dbg_valid_i  = 1'b1;
    uart_valid_i = 1'b1;
    #1;
    n_checks++;
    if (uart_accept_o !== 1'b1 || dbg_accept_o !== 1'b0) begin
      n_fails++;
      $display("FAIL burst_limit: acc=%b%b, want 01", dbg_accept_o, uart_accept_o);
    end
    @(negedge clk32_i);
    dbg_valid_i  = 1'b0;
    uart_valid_i = 1'b0;
    #1;
    n_checks++;
    if (dut.burst_cnt !== 8'd0 || owner_o !== 1'b1) begin
      n_fails++;
      $display("FAIL burst_clear: burst_cnt=%0d owner=%b, want 0 1", dut.burst_cnt, owner_o);
    end
    wait_idle("burst_limit");
  endtask

  initial begin
    test_reset();
    test_dbg_byte();
    test_uart_byte();
    test_back_to_back();
    test_reset_mid_frame();
    test_busy_pulse();
    test_burst_limit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
